// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Fetch stage in front of the IF/ID register. It owns the fetch PC, issues one
// instruction-memory request at a time (req/ack handshake, variable latency),
// buffers returned instructions together with their PCs in a small FIFO and
// presents the head entry to decode under a valid/ready handshake. A redirect
// from decode (taken branch, JMP, RET) flushes the queue and restarts fetching
// at the new PC. A request that is already in flight when a redirect arrives
// is completed on the memory side (req/addr held) and its data is discarded.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   PC_W      fetch address width
//   INST_W    instruction width
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk             clock, all state changes on the rising edge
//   reset           synchronous, active-high
//   redirect_valid  restart fetch at redirect_pc this cycle
//   redirect_pc     new fetch address
//   imem_req        fetch request, held high until imem_ack
//   imem_addr       fetch address, stable while imem_req is high
//   imem_ack        memory response, imem_data valid this cycle
//   imem_data       fetched instruction
//   inst_valid      head-of-queue instruction valid
//   inst_ready      decode accepts the head instruction
//   inst            head instruction
//   inst_pc         PC of the head instruction
//   q_count         number of entries held
//
// Optional feature (macro IFQ_PERF_CNT_EN):
//   empty_stall_cnt  cycles with inst_ready=1 and inst_valid=0 (saturating)
//   redirect_cnt     accepted redirects (saturating)
//   Without the macro these ports and counters do not exist; the fetch
//   behaviour is the same either way.
// -----------------------------------------------------------------------------
module inst_fetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 12,
    parameter int              INST_W   = 19,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   redirect_valid,
    input  logic [PC_W-1:0]        redirect_pc,
    output logic                   imem_req,
    output logic [PC_W-1:0]        imem_addr,
    input  logic                   imem_ack,
    input  logic [INST_W-1:0]      imem_data,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [INST_W-1:0]      inst,
    output logic [PC_W-1:0]        inst_pc,
    output logic [$clog2(DEPTH):0] q_count
`ifdef IFQ_PERF_CNT_EN
    ,
    output logic [15:0]            empty_stall_cnt,
    output logic [15:0]            redirect_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // IDLE    : no request outstanding (queue full, or just out of reset)
    // REQ     : request for fetch_pc outstanding, response will be queued
    // DISCARD : request outstanding whose response belongs to a flushed path
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    // fetch_pc is the next address to fetch (or the saved redirect target
    // while discarding); req_addr keeps the address of a request that has
    // been orphaned by a redirect so imem_addr stays stable until its ack.
    logic [PC_W-1:0]   fetch_pc;
    logic [PC_W-1:0]   req_addr;

    logic [INST_W-1:0] mem_inst [DEPTH];
    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  count;

    // Registered copy of the FIFO head so inst/inst_pc hold their last value
    // when the queue drains instead of showing a stale storage slot.
    logic [INST_W-1:0] head_inst;
    logic [PC_W-1:0]   head_pc;

    logic              pop;
    logic              push;
    logic [CNT_W-1:0]  cnt_after_pop;
    logic              issue_ok;
    logic              reissue_ok;

    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        // Natural wrap at 2^PC_W.
        return pc + PC_W'(1);
    endfunction

    assign inst_valid = (count != '0);
    assign inst       = head_inst;
    assign inst_pc    = head_pc;
    assign q_count    = count;

    // A redirect kills the head instruction, so it cannot be consumed in the
    // same cycle, and the in-flight response is not queued either.
    assign pop  = inst_valid && inst_ready && !redirect_valid;
    assign push = (state == REQ) && imem_ack && !redirect_valid;

    assign rd_ptr_nxt    = rd_ptr + PTR_W'(1);
    assign cnt_after_pop = count - CNT_W'(pop);

    // The pop of the current cycle frees a slot in time for a new request.
    // From IDLE nothing is pending; from REQ with an ack the entry being
    // pushed plus the next request must both fit.
    assign issue_ok   = (cnt_after_pop < DEPTH_C);
    assign reissue_ok = ((cnt_after_pop + CNT_W'(1)) < DEPTH_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        imem_req  = 1'b0;
        imem_addr = fetch_pc;
        case (state)
            IDLE: begin
                // A redirect empties the queue, so there is always room.
                if (redirect_valid || issue_ok) begin
                    state_n = REQ;
                end
            end
            REQ: begin
                imem_req = 1'b1;
                if (redirect_valid) begin
                    // With the ack in hand the old response is simply
                    // dropped; otherwise the request must be seen through.
                    state_n = imem_ack ? REQ : DISCARD;
                end else if (imem_ack) begin
                    state_n = reissue_ok ? REQ : IDLE;
                end
            end
            DISCARD: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
                if (imem_ack) begin
                    state_n = REQ;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Queue storage carries data only and is not reset; occupancy and the
    // head register decide what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= imem_data;
            mem_pc[wr_ptr]   <= fetch_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            req_addr  <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_inst <= '0;
            head_pc   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            // Entering DISCARD: remember the address still on the bus.
            // A later redirect while discarding only replaces fetch_pc.
            if ((state == REQ) && !imem_ack) begin
                req_addr <= fetch_pc;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                fetch_pc <= pc_inc(fetch_pc);
            end
            if (pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            count <= cnt_after_pop + CNT_W'(push);

            // Next head: the following stored entry if one remains after
            // the pop, otherwise the entry arriving this cycle (bypass).
            if (pop) begin
                if (count > CNT_W'(1)) begin
                    head_inst <= mem_inst[rd_ptr_nxt];
                    head_pc   <= mem_pc[rd_ptr_nxt];
                end else if (push) begin
                    head_inst <= imem_data;
                    head_pc   <= fetch_pc;
                end
            end else if (push && (count == '0)) begin
                head_inst <= imem_data;
                head_pc   <= fetch_pc;
            end
        end
    end

`ifdef IFQ_PERF_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            empty_stall_cnt <= '0;
            redirect_cnt    <= '0;
        end else begin
            if (inst_ready && !inst_valid) begin
                empty_stall_cnt <= sat_inc16(empty_stall_cnt);
            end
            if (redirect_valid) begin
                redirect_cnt <= sat_inc16(redirect_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
`timescale 1ns/1ps
module tb_inst_fetch_queue;

    localparam int PC_W   = 12;
    localparam int INST_W = 19;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              redirect_valid = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_data;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic [CNT_W-1:0]  q_count;

    // second instance: RESET_PC near the top of the address space
    logic              req2;
    logic [PC_W-1:0]   addr2;
    logic              ack2;
    logic [INST_W-1:0] data2;
    logic              valid2;
    logic [INST_W-1:0] inst2;
    logic [PC_W-1:0]   pc2;
    logic [CNT_W-1:0]  cnt2;

    // memory model controls
    logic auto_ack = 1'b1;
    logic man_ack  = 1'b0;
    int   lat      = 0;
    int   wait_cnt = 0;

    int checks    = 0;
    int failures  = 0;
    int pop_count = 0;
    logic [PC_W-1:0] sb [$];

    always #5 clk = ~clk;

    function automatic logic [INST_W-1:0] mem_word(input logic [PC_W-1:0] a);
        return {a[6:0] ^ 7'h2A, a};
    endfunction

    assign imem_data = mem_word(imem_addr);
    assign imem_ack  = auto_ack ? (imem_req && (wait_cnt >= lat)) : man_ack;
    assign data2     = mem_word(addr2);
    assign ack2      = req2;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

`ifdef IFQ_PERF_CNT_EN
    logic [15:0] esc1, rc1, esc2, rc2;
`endif

    inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .RESET_PC(12'h000)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .q_count(q_count)
`ifdef IFQ_PERF_CNT_EN
        , .empty_stall_cnt(esc1), .redirect_cnt(rc1)
`endif
    );

    inst_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W), .RESET_PC(12'hFFE)) dut_wrap (
        .clk(clk), .reset(reset), .redirect_valid(1'b0), .redirect_pc(12'h000),
        .imem_req(req2), .imem_addr(addr2), .imem_ack(ack2), .imem_data(data2),
        .inst_valid(valid2), .inst_ready(1'b1), .inst(inst2), .inst_pc(pc2),
        .q_count(cnt2)
`ifdef IFQ_PERF_CNT_EN
        , .empty_stall_cnt(esc2), .redirect_cnt(rc2)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_fill(input logic [PC_W-1:0] start, input int n);
        for (int i = 0; i < n; i++) sb.push_back(start + PC_W'(i));
    endtask

    // scoreboard: every instruction decode accepts is compared in order
    always @(negedge clk) begin
        if (!reset && inst_valid && inst_ready && !redirect_valid) begin
            pop_count++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual_pc=%0h expected=none", inst_pc);
            end else begin
                logic [PC_W-1:0] e;
                e = sb.pop_front();
                check("pop_pc", 32'(inst_pc), 32'(e));
                check("pop_inst", 32'(inst), 32'(mem_word(e)));
            end
        end
    end

    typedef struct {
        logic             rst;
        logic             rdy;
        logic             au;
        logic             mack;
        logic             e_req;
        logic [PC_W-1:0]  e_addr;
        logic             e_valid;
        logic [CNT_W-1:0] e_cnt;
        logic [PC_W-1:0]  e_pc;
    } vec_t;

    vec_t tbl [11];
    logic [PC_W-1:0] exp5 [4];

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        // zero-wait memory, decode stalled: fill to full, ack while idle, drain
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 3'd0, 12'h000};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h000, 1'b0, 3'd0, 12'h000};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h001, 1'b1, 3'd1, 12'h000};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h002, 1'b1, 3'd2, 12'h000};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h003, 1'b1, 3'd3, 12'h000};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h004, 1'b1, 3'd4, 12'h000};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h004, 1'b1, 3'd4, 12'h000};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h004, 1'b1, 3'd3, 12'h001};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h005, 1'b1, 3'd3, 12'h002};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h006, 1'b1, 3'd4, 12'h002};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 12'h006, 1'b1, 3'd3, 12'h003};
        exp5[0] = 12'hFFE; exp5[1] = 12'hFFF; exp5[2] = 12'h000; exp5[3] = 12'h001;

        sb_fill(12'h000, 64);
        for (int i = 0; i < 11; i++) begin
            reset      = tbl[i].rst;
            inst_ready = tbl[i].rdy;
            auto_ack   = tbl[i].au;
            man_ack    = tbl[i].mack;
            step();
            check($sformatf("v%0d_req", i),   32'(imem_req),   32'(tbl[i].e_req));
            check($sformatf("v%0d_addr", i),  32'(imem_addr),  32'(tbl[i].e_addr));
            check($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(tbl[i].e_valid));
            check($sformatf("v%0d_cnt", i),   32'(q_count),    32'(tbl[i].e_cnt));
            check($sformatf("v%0d_pc", i),    32'(inst_pc),    32'(tbl[i].e_pc));
        end
        p0 = pop_count;
        repeat (16) step();
        check("steady_pops", 32'(pop_count - p0), 32'd16);
        check("steady_cnt", 32'(q_count), 32'd3);

        // back-to-back delivery from reset; wrapping instance alongside
        reset = 1'b1; inst_ready = 1'b1;
        step();
        sb.delete(); sb_fill(12'h000, 64);
        reset = 1'b0;
        step(); step();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_valid%0d", i), 32'(inst_valid), 32'd1);
            check($sformatf("t1_pc%0d", i),    32'(inst_pc),    i);
            check($sformatf("t5_valid%0d", i), 32'(valid2),     32'd1);
            check($sformatf("t5_pc%0d", i),    32'(pc2),        32'(exp5[i]));
            check($sformatf("t5_inst%0d", i),  32'(inst2),      32'(mem_word(exp5[i])));
            check($sformatf("t5_cnt%0d", i),   32'(cnt2),       32'd1);
            step();
        end
        p0 = pop_count;
        repeat (10) step();
        check("t1_pops", 32'(pop_count - p0), 32'd10);

        // 3-cycle memory, redirect while the request is outstanding
        reset = 1'b1;
        step();
        sb.delete(); sb_fill(12'h040, 16);
        reset = 1'b0; lat = 3;
        step();
        check("t3_req", 32'(imem_req), 32'd1);
        step();
        redirect_valid = 1'b1; redirect_pc = 12'h040;
        step();
        redirect_valid = 1'b0;
        check("t3_hold_req", 32'(imem_req), 32'd1);
        check("t3_hold_addr", 32'(imem_addr), 32'h000);
        for (int n = 0; n < 10 && imem_addr == 12'h000; n++) step();
        check("t3_new_addr", 32'(imem_addr), 32'h040);
        check("t3_new_req", 32'(imem_req), 32'd1);
        check("t3_dropped", 32'(q_count), 32'd0);
        for (int n = 0; n < 10 && !inst_valid; n++) step();
        check("t3_first_valid", 32'(inst_valid), 32'd1);
        check("t3_first_pc", 32'(inst_pc), 32'h040);
        repeat (8) step();

        // two redirects while discarding: the later target wins
        reset = 1'b1;
        step();
        sb.delete(); sb_fill(12'h300, 16);
        reset = 1'b0;
        step(); step();
        redirect_valid = 1'b1; redirect_pc = 12'h200;
        step();
        redirect_pc = 12'h300;
        step();
        redirect_valid = 1'b0;
        check("t3b_hold_addr", 32'(imem_addr), 32'h000);
        for (int n = 0; n < 10 && imem_addr == 12'h000; n++) step();
        check("t3b_new_addr", 32'(imem_addr), 32'h300);
        for (int n = 0; n < 10 && !inst_valid; n++) step();
        check("t3b_first_pc", 32'(inst_pc), 32'h300);

        // redirect coincides with ack and with a pop, two entries queued
        reset = 1'b1; inst_ready = 1'b0; lat = 0;
        step();
        sb.delete(); sb_fill(12'h123, 16);
        reset = 1'b0;
        step(); step(); step();
        check("t4_cnt2", 32'(q_count), 32'd2);
        auto_ack = 1'b0; man_ack = 1'b1; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 12'h123;
        step();
        redirect_valid = 1'b0; man_ack = 1'b0; auto_ack = 1'b1;
        check("t4_cnt0", 32'(q_count), 32'd0);
        check("t4_valid0", 32'(inst_valid), 32'd0);
        check("t4_req", 32'(imem_req), 32'd1);
        check("t4_addr", 32'(imem_addr), 32'h123);
        check("t4_pc_hold", 32'(inst_pc), 32'h000);
        for (int n = 0; n < 10 && !inst_valid; n++) step();
        check("t4_first_pc", 32'(inst_pc), 32'h123);

        // reset while a request is outstanding
        reset = 1'b1; inst_ready = 1'b0;
        step();
        reset = 1'b0;
        step(); step(); step();
        lat = 3;
        step();
        check("t6_outstanding", 32'(imem_req), 32'd1);
        check("t6_cnt2", 32'(q_count), 32'd2);
        reset = 1'b1;
        step();
        check("t6_req_low", 32'(imem_req), 32'd0);
        check("t6_valid_low", 32'(inst_valid), 32'd0);
        check("t6_cnt0", 32'(q_count), 32'd0);
        sb.delete(); sb_fill(12'h000, 16);
        reset = 1'b0; lat = 0; inst_ready = 1'b1;
        step();
        check("t6_refetch_req", 32'(imem_req), 32'd1);
        check("t6_refetch_addr", 32'(imem_addr), 32'h000);
        step();
        check("t6_refetch_pc", 32'(inst_pc), 32'h000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
